vs_ring_buffer: RTL and testbench

VS_RING_BUFFER -- requirements
Module: vs_ring_buffer

---
 rtl/vs_ring_buffer.sv | 151 +++++++++++++++
 tb/tb_vs_ring_buffer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vs_ring_buffer.sv
// Wishbone-readable sample ring buffer: a producer pushes 15-bit samples, the host drains them
// through an INDIRECT register and can freeze or clear the buffer. Optional: VS_RING_OVERFLOW_FLAG_EN.
module vs_ring_buffer #(
  parameter int DEPTH_BITS = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic        wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        vs_wr_i,
  input  logic [14:0] vs_dat_i,
  output logic        vs_frozen_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   C_CNT_FULL = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   C_CNT_ONE  = 1;
  localparam logic [DEPTH_BITS-1:0] C_PTR_ONE  = 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  state_t                r_state;
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic [14:0]           r_mem [DEPTH];
  logic                  r_ack;
  logic                  r_err;
  logic [15:0]           r_dat;

  logic        w_req;
  logic        w_wr_ind;
  logic        w_freeze;
  logic        w_clear;
  logic        w_bad_wr;
  logic        w_rd;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push_en;
  logic        w_overwrite;
  logic        w_ovf;
  logic [15:0] w_rd_dat;

  // Handshake: a transfer is taken in any cycle with cyc&stb, except the cycle in which the
  // previous one is being terminated. Exactly one of ack/err follows one cycle later, for one cycle.
  assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_wr_ind    = w_req & wb_we_i & ~wb_adr_i;
  assign w_freeze    = w_wr_ind & (wb_dat_i == 16'h0000);
  assign w_clear     = w_wr_ind & (wb_dat_i == 16'hffff);
  assign w_bad_wr    = w_req & wb_we_i & ~w_freeze & ~w_clear;
  assign w_rd        = w_req & ~wb_we_i;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_CNT_FULL);
  assign w_pop       = w_rd & ~wb_adr_i & ~w_empty;
  assign w_push_en   = vs_wr_i & (r_state == ST_RUN) & ~w_clear;
  // A coincident pop frees the oldest slot first, so a full-buffer push only overwrites without one.
  assign w_overwrite = w_push_en & w_full & ~w_pop;

  always_comb begin
    w_rd_dat = 16'h0000;
    if (wb_adr_i) begin
      w_rd_dat = {w_ovf, 15'(r_count)};
    end else if (w_empty) begin
      w_rd_dat = 16'h8000;
    end else begin
      w_rd_dat = {(r_count == C_CNT_ONE), r_mem[r_rd_ptr]};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= vs_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_RUN;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= 16'h0000;
    end else begin
      r_ack <= w_req & ~w_bad_wr;
      r_err <= w_bad_wr;
      r_dat <= w_rd ? w_rd_dat : 16'h0000;

      if (w_clear) begin
        r_state  <= ST_RUN;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_freeze) begin
          r_state <= ST_FROZEN;
        end
        if (w_push_en) begin
          r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
        if (w_pop || w_overwrite) begin
          r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
        if (w_push_en && !w_pop && !w_full) begin
          r_count <= r_count + C_CNT_ONE;
        end else if (w_pop && !w_push_en) begin
          r_count <= r_count - C_CNT_ONE;
        end
      end
    end
  end

`ifdef VS_RING_OVERFLOW_FLAG_EN
  logic r_ovf;
  logic w_drop;

  assign w_drop = vs_wr_i & (r_state == ST_FROZEN) & ~w_clear;

  // Sticky: any lost sample (overwritten or discarded while frozen) sets it until reset or clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_ovf <= 1'b0;
    end else if (w_overwrite || w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign w_ovf = r_ovf;
`else
  assign w_ovf = 1'b0;
`endif

  assign wb_ack_o    = r_ack;
  assign wb_err_o    = r_err;
  assign wb_dat_o    = r_dat;
  assign vs_frozen_o = (r_state == ST_FROZEN);

endmodule

// File: tb/tb_vs_ring_buffer.sv
// Self-checking bench for vs_ring_buffer (DEPTH_BITS=4): directed scenarios plus randomized
// traffic against a queue-based model of the buffer.
module tb_vs_ring_buffer;

  localparam int DB    = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        adr;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic        ack;
  logic        err;
  logic        vs_wr;
  logic [14:0] vs_dat;
  logic        frozen;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [14:0] exp_q[$];
  logic        m_frozen;
  logic        m_ovf;

  vs_ring_buffer #(.DEPTH_BITS(DB)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_we_i     (we),
    .wb_adr_i    (adr),
    .wb_dat_i    (wdat),
    .wb_dat_o    (rdat),
    .wb_ack_o    (ack),
    .wb_err_o    (err),
    .vs_wr_i     (vs_wr),
    .vs_dat_i    (vs_dat),
    .vs_frozen_o (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ovf_bit();
`ifdef VS_RING_OVERFLOW_FLAG_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_frozen = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One bus transfer (optional) with an optional coincident push. Returns DUT outputs
  // seen in the termination cycle and the model's expectation for them.
  task automatic do_op(input logic c, input logic w, input logic a, input logic [15:0] wd,
                       input logic p, input logic [14:0] pd,
                       output logic [15:0] o_dat, output logic o_ack, output logic o_err,
                       output logic [15:0] e_dat, output logic e_ack, output logic e_err);
    e_dat = 16'h0000;
    e_ack = 1'b0;
    e_err = 1'b0;
    if (c) begin
      if (w) begin
        if (!a && (wd == 16'h0000 || wd == 16'hffff)) e_ack = 1'b1;
        else e_err = 1'b1;
      end else begin
        e_ack = 1'b1;
        if (a) e_dat = {ovf_bit(), 15'(exp_q.size())};
        else if (exp_q.size() == 0) e_dat = 16'h8000;
        else e_dat = {exp_q.size() == 1, exp_q[0]};
      end
    end
    if (c && w && !a && wd == 16'hffff) begin
      model_reset();
    end else begin
      if (c && !w && !a && exp_q.size() > 0) void'(exp_q.pop_front());
      if (p) begin
        if (m_frozen) begin
          m_ovf = 1'b1;
        end else begin
          if (exp_q.size() == DEPTH) begin
            void'(exp_q.pop_front());
            m_ovf = 1'b1;
          end
          exp_q.push_back(pd);
        end
      end
      if (c && w && !a && wd == 16'h0000) m_frozen = 1'b1;
    end

    cyc = c; stb = c; we = w; adr = a; wdat = wd;
    vs_wr = p; vs_dat = pd;
    tick();
    o_dat = rdat;
    o_ack = ack;
    o_err = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0; wdat = 16'h0000;
    vs_wr = 1'b0; vs_dat = 15'h0000;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] d, ed;
    logic a, e, ea, ee;
    rst = 1'b1;
    cyc = 1'b1; stb = 1'b1; adr = 1'b1;
    repeat (3) tick();
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; adr = 1'b0;
    model_reset();
    n_checks++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_term: ack=%b err=%b required 0/0", ack, err);
    end
    n_checks++;
    if (rdat !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_dat: got %h required 0000", rdat);
    end
    n_checks++;
    if (frozen !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_frozen: got %b required 0", frozen);
    end
    tick();
    n_checks++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_abort: ack=%b err=%b required 0/0", ack, err);
    end
    do_op(1, 0, 1, 0, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (d !== 16'h0000 || a !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_status: dat=%h ack=%b required 0000/1", d, a);
    end
  endtask

  task automatic test_freeze_read();
    logic [15:0] d, ed;
    logic a, e, ea, ee;
    logic [15:0] req_v [4];
    req_v[0] = 16'h0011; req_v[1] = 16'h0022; req_v[2] = 16'h8033; req_v[3] = 16'h8000;
    do_op(1, 1, 0, 16'hffff, 0, 0, d, a, e, ed, ea, ee);
    do_op(0, 0, 0, 0, 1, 15'h0011, d, a, e, ed, ea, ee);
    do_op(0, 0, 0, 0, 1, 15'h0022, d, a, e, ed, ea, ee);
    do_op(0, 0, 0, 0, 1, 15'h0033, d, a, e, ed, ea, ee);
    do_op(1, 1, 0, 16'h0000, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (a !== 1'b1 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL freeze_ack: ack=%b err=%b required 1/0", a, e);
    end
    for (int i = 0; i < 4; i++) begin
      do_op(1, 0, 0, 0, 0, 0, d, a, e, ed, ea, ee);
      n_checks++;
      if (d !== req_v[i] || a !== 1'b1) begin
        n_errors++;
        $display("FAIL freeze_read%0d: dat=%h ack=%b required %h/1", i, d, a, req_v[i]);
      end
    end
    n_checks++;
    if (frozen !== 1'b1) begin
      n_errors++;
      $display("FAIL freeze_state: got %b required 1", frozen);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d, ed, req;
    logic a, e, ea, ee;
    do_op(1, 1, 0, 16'hffff, 0, 0, d, a, e, ed, ea, ee);
    for (int v = 1; v <= 20; v++) begin
      do_op(0, 0, 0, 0, 1, 15'(v), d, a, e, ed, ea, ee);
    end
    do_op(1, 0, 1, 0, 0, 0, d, a, e, ed, ea, ee);
`ifdef VS_RING_OVERFLOW_FLAG_EN
    req = 16'h8010;
`else
    req = 16'h0010;
`endif
    n_checks++;
    if (d !== req) begin
      n_errors++;
      $display("FAIL ovf_status: got %h required %h", d, req);
    end
    for (int v = 5; v <= 20; v++) begin
      do_op(1, 0, 0, 0, 0, 0, d, a, e, ed, ea, ee);
      req = (v == 20) ? 16'h8014 : 16'(v);
      n_checks++;
      if (d !== req) begin
        n_errors++;
        $display("FAIL ovf_read%0d: got %h required %h", v, d, req);
      end
    end
  endtask

  task automatic test_clear_frozen();
    logic [15:0] d, ed;
    logic a, e, ea, ee;
    do_op(1, 1, 0, 16'hffff, 0, 0, d, a, e, ed, ea, ee);
    do_op(0, 0, 0, 0, 1, 15'h0001, d, a, e, ed, ea, ee);
    do_op(0, 0, 0, 0, 1, 15'h0002, d, a, e, ed, ea, ee);
    do_op(1, 1, 0, 16'h0000, 0, 0, d, a, e, ed, ea, ee);
    do_op(0, 0, 0, 0, 1, 15'h0055, d, a, e, ed, ea, ee);
    do_op(1, 1, 0, 16'hffff, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (frozen !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_frozen: got %b required 0", frozen);
    end
    do_op(1, 0, 1, 0, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (d !== 16'h0000) begin
      n_errors++;
      $display("FAIL clear_status: got %h required 0000", d);
    end
    // Clear coinciding with a push: push must be dropped.
    do_op(1, 1, 0, 16'hffff, 1, 15'h0777, d, a, e, ed, ea, ee);
    do_op(1, 0, 1, 0, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (d !== 16'h0000) begin
      n_errors++;
      $display("FAIL clear_push: got %h required 0000", d);
    end
  endtask

  task automatic test_bad_write();
    logic [15:0] d, ed;
    logic a, e, ea, ee;
    do_op(1, 1, 0, 16'hffff, 0, 0, d, a, e, ed, ea, ee);
    for (int i = 0; i < 3; i++) do_op(0, 0, 0, 0, 1, 15'(i + 7), d, a, e, ed, ea, ee);
    do_op(1, 1, 0, 16'h1234, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (e !== 1'b1 || a !== 1'b0) begin
      n_errors++;
      $display("FAIL badwr_ind: err=%b ack=%b required 1/0", e, a);
    end
    do_op(1, 1, 1, 16'h0000, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (e !== 1'b1 || a !== 1'b0) begin
      n_errors++;
      $display("FAIL badwr_status: err=%b ack=%b required 1/0", e, a);
    end
    n_checks++;
    if (frozen !== 1'b0) begin
      n_errors++;
      $display("FAIL badwr_state: got %b required 0", frozen);
    end
    do_op(1, 0, 1, 0, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (d !== 16'h0003) begin
      n_errors++;
      $display("FAIL badwr_count: got %h required 0003", d);
    end
  endtask

  task automatic test_push_pop();
    logic [15:0] d, ed;
    logic a, e, ea, ee;
    do_op(1, 1, 0, 16'hffff, 0, 0, d, a, e, ed, ea, ee);
    for (int i = 0; i < 5; i++) do_op(0, 0, 0, 0, 1, 15'(16'h0100 + i), d, a, e, ed, ea, ee);
    do_op(1, 0, 0, 0, 1, 15'h0200, d, a, e, ed, ea, ee);
    n_checks++;
    if (d !== 16'h0100) begin
      n_errors++;
      $display("FAIL pp_read: got %h required 0100", d);
    end
    do_op(1, 0, 1, 0, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (d !== 16'h0005) begin
      n_errors++;
      $display("FAIL pp_count: got %h required 0005", d);
    end
    // Full buffer: simultaneous pop+push is not an overwrite.
    for (int i = 0; i < 11; i++) do_op(0, 0, 0, 0, 1, 15'(16'h0300 + i), d, a, e, ed, ea, ee);
    do_op(1, 0, 0, 0, 1, 15'h0400, d, a, e, ed, ea, ee);
    n_checks++;
    if (d !== 16'h0101) begin
      n_errors++;
      $display("FAIL pp_full_read: got %h required 0101", d);
    end
    do_op(1, 0, 1, 0, 0, 0, d, a, e, ed, ea, ee);
    n_checks++;
    if (d !== 16'h0010) begin
      n_errors++;
      $display("FAIL pp_full_count: got %h required 0010", d);
    end
  endtask

  task automatic test_back_to_back();
    logic req;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      req = (i % 2 == 0);
      n_checks++;
      if (ack !== req || err !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_ack%0d: ack=%b err=%b required %b/0", i, ack, err, req);
      end
    end
    cyc = 1'b0; stb = 1'b0; adr = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] d, ed, wd;
    logic a, e, ea, ee, c, w, ad, p;
    int r;
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      c  = 1'b1; w = 1'b0; ad = 1'b0; wd = 16'h0000;
      p  = 1'($urandom_range(0, 1));
      if (r < 20) begin
        c = 1'b0; p = 1'b1;
      end else if (r < 50) begin
        ad = 1'b0;
      end else if (r < 70) begin
        ad = 1'b1;
      end else if (r < 74) begin
        w = 1'b1;
      end else if (r < 77) begin
        w = 1'b1; wd = 16'hffff;
      end else if (r < 82) begin
        w = 1'b1; ad = 1'($urandom_range(0, 1)); wd = 16'($urandom_range(1, 16'hfffe));
      end else begin
        c = 1'b0; p = 1'b1;
      end
      do_op(c, w, ad, wd, p, 15'($urandom_range(0, 32767)), d, a, e, ed, ea, ee);
      n_checks++;
      if (a !== ea || e !== ee) begin
        n_errors++;
        $display("FAIL rand_term%0d: ack=%b err=%b required %b/%b", n, a, e, ea, ee);
      end
      if (c && !w) begin
        n_checks++;
        if (d !== ed) begin
          n_errors++;
          $display("FAIL rand_dat%0d: got %h required %h", n, d, ed);
        end
      end
      n_checks++;
      if (frozen !== m_frozen) begin
        n_errors++;
        $display("FAIL rand_frozen%0d: got %b required %b", n, frozen, m_frozen);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0;
    wdat = 16'h0000; vs_wr = 1'b0; vs_dat = 15'h0000;
    model_reset();
    test_reset();
    test_freeze_read();
    test_overflow();
    test_clear_frozen();
    test_bad_write();
    test_push_pop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
